ssp_rx_shift: RTL and testbench

Receive-side datapath of the full-custom SSP module and the counterpart of the transmit shift register. It deserialises MSB-first frames from the serial data line under a bit strobe, detects frame boundaries from the frame-sync input, and buffers completed words in a small show-ahead FIFO. The register/bus interface reads the FIFO. It sits between the SSP pin-side logic, which supplies synchronised `rxd_i`, `fss_i` and `sclk_en_i`, and the SSP control block.

---
 rtl/ssp_pkg.sv | 19 +
 rtl/ssp_rx_fifo.sv | 78 +++++++
 rtl/ssp_rx_shift.sv | 122 ++++++++++++
 tb/tb_ssp_rx_shift.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// Constants and types shared by the SSP transmit and receive datapaths.
package ssp_pkg;

    localparam int SSP_DATA_W     = 8;
    localparam int SSP_FIFO_DEPTH = 4;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

    // The level counter needs one extra bit so that a full FIFO is distinguishable from an empty one.
    function automatic int ssp_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int SSP_LEVEL_W = ssp_level_w(SSP_FIFO_DEPTH);

endpackage

// File: rtl/ssp_rx_fifo.sv
// Synchronous show-ahead FIFO: the head word is held in a register so data_o is valid
// the cycle after the first push and keeps its last value while the FIFO is empty.
module ssp_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_dout;

    logic             w_empty;
    logic             w_full;
    logic             w_wr_en;
    logic             w_rd_en;
    logic [AW-1:0]    w_rd_ptr_nxt;

    assign w_empty      = (r_level == '0);
    assign w_full       = (r_level == LW'(DEPTH));
    // When full, a same-cycle pop frees the slot being written, so the push is still accepted.
    assign w_wr_en      = push_i && (!w_full || pop_i);
    assign w_rd_en      = pop_i && !w_empty;
    assign w_rd_ptr_nxt = r_rd_ptr + AW'(1);

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            r_level <= r_level + LW'(w_wr_en) - LW'(w_rd_en);

            if (w_empty && w_wr_en) begin
                r_dout <= din_i;
            end else if (w_rd_en) begin
                if (r_level > LW'(1)) begin
                    r_dout <= r_mem[w_rd_ptr_nxt];
                end else if (w_wr_en) begin
                    r_dout <= din_i;
                end
            end
        end
    end

    assign dout_o  = r_dout;
    assign empty_o = w_empty;
    assign full_o  = w_full;
    assign level_o = r_level;

endmodule

// File: rtl/ssp_rx_shift.sv
// SSP receive path: frame-sync driven deserialiser feeding a show-ahead FIFO, with
// sticky overrun and frame-error flags.
module ssp_rx_shift
    import ssp_pkg::*;
#(
    parameter int DATA_W     = SSP_DATA_W,
    parameter int FIFO_DEPTH = SSP_FIFO_DEPTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rxd_i,
    input  logic                          fss_i,
    input  logic                          sclk_en_i,
    input  logic                          rd_i,
    input  logic                          clr_err_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          busy_o,
    output logic                          overrun_o,
    output logic                          frame_err_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_t         r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_overrun;
    logic              r_frame_err;

    logic              w_shift_strobe;
    logic              w_last;
    logic              w_push;
    logic              w_frame_err;
    logic              w_overrun;
    logic              w_full;
    logic [DATA_W-1:0] w_word;

    assign w_shift_strobe = sclk_en_i && (r_state == RX_SHIFT);
    assign w_last         = (r_bit_cnt == LAST_BIT);
    assign w_word         = {r_shreg[DATA_W-2:0], rxd_i};
    assign w_push         = w_shift_strobe && w_last;
    assign w_frame_err    = w_shift_strobe && fss_i && !w_last;
    assign w_overrun      = w_push && w_full && !rd_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= RX_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (sclk_en_i) begin
            case (r_state)
                RX_IDLE: begin
                    if (fss_i) begin
                        r_state   <= RX_SHIFT;
                        r_bit_cnt <= '0;
                    end
                end
                RX_SHIFT: begin
                    if (w_frame_err) begin
                        // The sync strobe restarts the frame; it carries no data bit.
                        r_shreg   <= '0;
                        r_bit_cnt <= '0;
                    end else if (w_last) begin
                        r_shreg   <= w_word;
                        r_bit_cnt <= '0;
                        r_state   <= fss_i ? RX_SHIFT : RX_IDLE;
                    end else begin
                        r_shreg   <= w_word;
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= RX_IDLE;
                end
            endcase
        end
    end

    // Setting beats clearing when both happen in one cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_overrun) begin
                r_overrun <= 1'b1;
            end else if (clr_err_i) begin
                r_overrun <= 1'b0;
            end
            if (w_frame_err) begin
                r_frame_err <= 1'b1;
            end else if (clr_err_i) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    ssp_rx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (rd_i),
        .din_i   (w_word),
        .dout_o  (data_o),
        .empty_o (empty_o),
        .full_o  (w_full),
        .level_o (level_o)
    );

    assign full_o      = w_full;
    assign busy_o      = (r_state == RX_SHIFT);
    assign overrun_o   = r_overrun;
    assign frame_err_o = r_frame_err;

endmodule

// File: tb/tb_ssp_rx_shift.sv
// Directed bench for ssp_rx_shift: hand-computed vectors checked with immediate assertions.
module tb_ssp_rx_shift;
    import ssp_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   rxd = 1'b0;
    logic                   fss = 1'b0;
    logic                   sclk_en = 1'b0;
    logic                   rd = 1'b0;
    logic                   clr_err = 1'b0;
    logic [SSP_DATA_W-1:0]  data_o;
    logic                   empty_o;
    logic                   full_o;
    logic [SSP_LEVEL_W-1:0] level_o;
    logic                   busy_o;
    logic                   overrun_o;
    logic                   frame_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ssp_rx_shift dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .rxd_i       (rxd),
        .fss_i       (fss),
        .sclk_en_i   (sclk_en),
        .rd_i        (rd),
        .clr_err_i   (clr_err),
        .data_o      (data_o),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .level_o     (level_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o),
        .frame_err_o (frame_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic d, input logic f, input logic r);
        sclk_en = 1'b1;
        rxd     = d;
        fss     = f;
        rd      = r;
        tick();
        sclk_en = 1'b0;
        fss     = 1'b0;
        rd      = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] v, input logic sync,
                              input logic fss_last, input logic rd_last);
        if (sync) strobe(1'b0, 1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            strobe(v[i], (i == 0) && fss_last, (i == 0) && rd_last);
        end
    endtask

    task automatic pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic clear();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"},  data_o,      32'h0);
        chk({tag, "_empty"}, empty_o,     32'h1);
        chk({tag, "_full"},  full_o,      32'h0);
        chk({tag, "_level"}, level_o,     32'h0);
        chk({tag, "_busy"},  busy_o,      32'h0);
        chk({tag, "_ovr"},   overrun_o,   32'h0);
        chk({tag, "_ferr"},  frame_err_o, 32'h0);
    endtask

    initial begin
        logic [7:0] v;

        // Reset state
        tick();
        tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic receive of 8'h5A
        strobe(1'b0, 1'b1, 1'b0);
        chk("basic_busy_rise", busy_o, 32'h1);
        chk("basic_empty_pre", empty_o, 32'h1);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        chk("basic_data",  data_o,  32'h5A);
        chk("basic_empty", empty_o, 32'h0);
        chk("basic_level", level_o, 32'h1);
        chk("basic_busy_fall", busy_o, 32'h0);
        pop();
        chk("basic_pop_empty", empty_o, 32'h1);
        chk("basic_pop_level", level_o, 32'h0);
        chk("basic_pop_hold",  data_o,  32'h5A);

        // Back-to-back frames A5 then 3C, strobes every cycle
        strobe(1'b0, 1'b1, 1'b0);
        v = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            strobe(v[i], i == 0, 1'b0);
            chk("b2b_busy_a", busy_o, 32'h1);
        end
        v = 8'h3C;
        for (int i = 7; i >= 1; i--) begin
            strobe(v[i], 1'b0, 1'b0);
            chk("b2b_busy_b", busy_o, 32'h1);
        end
        strobe(v[0], 1'b0, 1'b0);
        chk("b2b_level", level_o, 32'h2);
        chk("b2b_head",  data_o,  32'hA5);
        chk("b2b_ferr",  frame_err_o, 32'h0);
        chk("b2b_ovr",   overrun_o,   32'h0);
        pop();
        chk("b2b_second", data_o, 32'h3C);
        pop();
        chk("b2b_empty", empty_o, 32'h1);

        // Overrun
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0, 1'b0);
        chk("ovr_full4",  full_o,    32'h1);
        chk("ovr_level4", level_o,   32'h4);
        chk("ovr_none",   overrun_o, 32'h0);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        chk("ovr_set",    overrun_o, 32'h1);
        chk("ovr_level",  level_o,   32'h4);
        chk("ovr_head",   data_o,    32'h11);
        clear();
        chk("ovr_clr",    overrun_o, 32'h0);
        send_frame(8'h66, 1'b1, 1'b0, 1'b1);
        chk("ovr_pushpop_flag",  overrun_o, 32'h0);
        chk("ovr_pushpop_level", level_o,   32'h4);
        chk("ovr_pushpop_head",  data_o,    32'h22);
        pop();
        chk("ovr_rd33", data_o, 32'h33);
        chk("ovr_notfull", full_o, 32'h0);
        pop();
        chk("ovr_rd44", data_o, 32'h44);
        pop();
        chk("ovr_rd66", data_o, 32'h66);
        pop();
        chk("ovr_empty", empty_o, 32'h1);

        // Frame error on the 4th data strobe, then C3
        strobe(1'b0, 1'b1, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 1'b0);
        chk("ferr_pre", frame_err_o, 32'h0);
        strobe(1'b1, 1'b1, 1'b0);
        chk("ferr_set",   frame_err_o, 32'h1);
        chk("ferr_busy",  busy_o,      32'h1);
        chk("ferr_level", level_o,     32'h0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
        chk("ferr_level1", level_o, 32'h1);
        chk("ferr_data",   data_o,  32'hC3);
        pop();
        clear();
        chk("ferr_clr", frame_err_o, 32'h0);
        strobe(1'b0, 1'b1, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 1'b0);
        clr_err = 1'b1;
        strobe(1'b0, 1'b1, 1'b0);
        clr_err = 1'b0;
        chk("ferr_set_wins", frame_err_o, 32'h1);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        chk("ferr_f0", data_o, 32'hF0);
        pop();
        clear();

        // Reset mid-frame
        send_frame(8'h77, 1'b1, 1'b0, 1'b0);
        chk("rst_pre_level", level_o, 32'h1);
        v = 8'h81;
        strobe(1'b0, 1'b1, 1'b0);
        for (int i = 7; i >= 3; i--) strobe(v[i], 1'b0, 1'b0);
        chk("rst_pre_busy", busy_o, 32'h1);
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("rst_mid");
        rst_n = 1'b1;
        tick();
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        chk("rst_after_data",  data_o,  32'h81);
        chk("rst_after_level", level_o, 32'h1);
        pop();
        chk("rst_after_empty", empty_o, 32'h1);

        // Idle noise: strobes without sync and reads of an empty FIFO
        for (int i = 0; i < 10; i++) begin
            strobe(i[0], 1'b0, (i % 3) == 0);
            chk("idle_level", level_o, 32'h0);
            chk("idle_busy",  busy_o,  32'h0);
        end
        chk("idle_empty", empty_o,     32'h1);
        chk("idle_data",  data_o,      32'h81);
        chk("idle_ovr",   overrun_o,   32'h0);
        chk("idle_ferr",  frame_err_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
